// File: rtl/ex_mem_stage_pkg.sv
// Shared types for the EX->MEM pipeline register.
//   mem_size_t : funct3 encodings of load/store access size
//   ex_mem_t   : registered MEM-stage bundle
//   PC_INCR    : link offset for JAL/JALR (PC of the next sequential instr)
package ex_mem_stage_pkg;

  localparam int XLEN_P  = 32;
  localparam int PC_INCR = 4;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_t;

  // mem_size is kept as raw funct3 so non-memory instructions can carry
  // whatever bits the decoder produced without an illegal enum value.
  typedef struct packed {
    logic              valid;
    logic [XLEN_P-1:0] pc;
    logic [XLEN_P-1:0] alu_result;
    logic [XLEN_P-1:0] rs2;
    logic [4:0]        rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [2:0]        mem_size;
  } ex_mem_t;

endpackage

// File: rtl/ex_mem_stage_branch_resolve.sv
// Combinational branch/jump resolution for the instruction in EX.
//   acc_i            : instruction is being accepted this cycle
//   pc_i/imm_i       : EX PC and sign-extended immediate
//   alu_result_i     : ALU output (rs1+imm for JALR)
//   bit_branch_i     : branch-compare result from the ALU
//   is_branch_i/is_jal_i/is_jalr_i : control-transfer kind
//   taken_o          : control transfer happens
//   target_o         : destination PC
//   link_o           : PC + 4 written to rd by JAL/JALR
//   misaligned_o     : target bit1 set (only meaningful when taken_o)
module branch_resolve
  import ex_mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            acc_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic            bit_branch_i,
  input  logic            is_branch_i,
  input  logic            is_jal_i,
  input  logic            is_jalr_i,
  output logic            taken_o,
  output logic [XLEN-1:0] target_o,
  output logic [XLEN-1:0] link_o,
  output logic            misaligned_o
);

  assign taken_o  = acc_i & ((is_branch_i & bit_branch_i) | is_jal_i | is_jalr_i);
  // JALR clears bit0 of rs1+imm; others are PC-relative, wrapping mod 2^XLEN.
  assign target_o = is_jalr_i ? {alu_result_i[XLEN-1:1], 1'b0} : (pc_i + imm_i);
  assign link_o   = pc_i + XLEN'(PC_INCR);
  assign misaligned_o = taken_o & target_o[1];

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with branch/jump resolution.
//   clk, rst           : clock, synchronous active-high reset
//   ex_*_i             : EX-stage instruction bundle and ALU results
//   stall_i            : hold the MEM register (memory not ready)
//   flush_i            : insert a bubble instead of the EX instruction
//   mem_*_o            : registered MEM-stage bundle
//   redirect_o/_pc_o   : one-cycle fetch redirect and its target
//   misalign_trap_o    : one-cycle pulse, taken target had bit1 set
// The instruction sitting in EX during a redirect cycle is wrong-path and
// is turned into a bubble via the internal squash flag.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] ex_imm_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic            bit_branch_i,
  input  logic            ex_is_branch_i,
  input  logic            ex_is_jal_i,
  input  logic            ex_is_jalr_i,
  input  logic [XLEN-1:0] ex_rs2_i,
  input  logic [4:0]      ex_rd_i,
  input  logic            ex_reg_write_i,
  input  logic            ex_mem_read_i,
  input  logic            ex_mem_write_i,
  input  logic [2:0]      ex_mem_size_i,
  input  logic            stall_i,
  input  logic            flush_i,
  output logic            mem_valid_o,
  output logic [XLEN-1:0] mem_pc_o,
  output logic [XLEN-1:0] mem_alu_result_o,
  output logic [XLEN-1:0] mem_rs2_o,
  output logic [4:0]      mem_rd_o,
  output logic            mem_reg_write_o,
  output logic            mem_mem_read_o,
  output logic            mem_mem_write_o,
  output logic [2:0]      mem_mem_size_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            misalign_trap_o
);

  ex_mem_t         mem_q, mem_d;
  logic            squash_q;
  logic            redirect_q, redirect_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] redirect_pc_q;

  logic            acc;
  logic            taken;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] link;
  logic            misaligned;
  logic            kill_wb;

  // flush beats both the squash and a taken decision
  assign acc = ex_valid_i & ~squash_q & ~flush_i;

  branch_resolve #(.XLEN(XLEN)) u_resolve (
    .acc_i        (acc),
    .pc_i         (ex_pc_i),
    .imm_i        (ex_imm_i),
    .alu_result_i (alu_result_i),
    .bit_branch_i (bit_branch_i),
    .is_branch_i  (ex_is_branch_i),
    .is_jal_i     (ex_is_jal_i),
    .is_jalr_i    (ex_is_jalr_i),
    .taken_o      (taken),
    .target_o     (target),
    .link_o       (link),
    .misaligned_o (misaligned)
  );

  // A misaligned jump still occupies MEM (so the trap has a PC) but must
  // not write rd or touch memory.
  assign kill_wb = ~acc | misaligned;

  always_comb begin
    mem_d            = '0;
    mem_d.valid      = acc;
    mem_d.pc         = ex_pc_i;
    mem_d.alu_result = (ex_is_jal_i | ex_is_jalr_i) ? link : alu_result_i;
    mem_d.rs2        = ex_rs2_i;
    mem_d.rd         = ex_rd_i;
    // conditional branches never write rd, taken or not
    mem_d.reg_write  = ex_reg_write_i & ~ex_is_branch_i & ~kill_wb;
    mem_d.mem_read   = ex_mem_read_i  & ~kill_wb;
    mem_d.mem_write  = ex_mem_write_i & ~kill_wb;
    mem_d.mem_size   = ex_mem_size_i;
    redirect_d       = taken & ~misaligned;
    misalign_d       = misaligned;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q         <= '0;
      mem_q.pc      <= RESET_PC;
      squash_q      <= 1'b0;
      redirect_q    <= 1'b0;
      misalign_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else if (stall_i) begin
      // Events are pulses; the squash flag survives the stall so the
      // wrong-path instruction is still killed once EX advances.
      redirect_q    <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      squash_q      <= redirect_d;
      redirect_q    <= redirect_d;
      misalign_q    <= misalign_d;
      redirect_pc_q <= target;
    end
  end

  assign mem_valid_o      = mem_q.valid;
  assign mem_pc_o         = mem_q.pc;
  assign mem_alu_result_o = mem_q.alu_result;
  assign mem_rs2_o        = mem_q.rs2;
  assign mem_rd_o         = mem_q.rd;
  assign mem_reg_write_o  = mem_q.reg_write;
  assign mem_mem_read_o   = mem_q.mem_read;
  assign mem_mem_write_o  = mem_q.mem_write;
  assign mem_mem_size_o   = mem_q.mem_size;
  assign redirect_o       = redirect_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign misalign_trap_o  = misalign_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;
  import ex_mem_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst, ex_valid, bb, is_br, is_jal, is_jalr, rw, mr, mw, stall, flush;
  logic [31:0] ex_pc, ex_imm, alu, rs2;
  logic [4:0]  rd;
  logic [2:0]  sz;

  logic        mem_valid, mem_rw, mem_mr, mem_mw, redirect, mis_trap;
  logic [31:0] mem_pc, mem_alu, mem_rs2, redirect_pc;
  logic [4:0]  mem_rd;
  logic [2:0]  mem_sz;

  always #5 clk = ~clk;

  ex_mem_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid), .ex_pc_i(ex_pc), .ex_imm_i(ex_imm),
    .alu_result_i(alu), .bit_branch_i(bb),
    .ex_is_branch_i(is_br), .ex_is_jal_i(is_jal), .ex_is_jalr_i(is_jalr),
    .ex_rs2_i(rs2), .ex_rd_i(rd), .ex_reg_write_i(rw),
    .ex_mem_read_i(mr), .ex_mem_write_i(mw), .ex_mem_size_i(sz),
    .stall_i(stall), .flush_i(flush),
    .mem_valid_o(mem_valid), .mem_pc_o(mem_pc), .mem_alu_result_o(mem_alu),
    .mem_rs2_o(mem_rs2), .mem_rd_o(mem_rd), .mem_reg_write_o(mem_rw),
    .mem_mem_read_o(mem_mr), .mem_mem_write_o(mem_mw), .mem_mem_size_o(mem_sz),
    .redirect_o(redirect), .redirect_pc_o(redirect_pc), .misalign_trap_o(mis_trap)
  );

  typedef struct packed {
    logic rst, stall, flush, v;
    logic [31:0] pc, imm, alu;
    logic bb, br, jal, jalr;
    logic [31:0] rs2;
    logic [4:0] rd;
    logic rw, mr, mw;
    logic [2:0] sz;
  } in_t;

  typedef struct packed {
    logic v;
    logic [31:0] pc, alu, rs2;
    logic [4:0] rd;
    logic rw, mr, mw;
    logic [2:0] sz;
    logic redir;
    logic [31:0] rpc;
    logic mis;
  } obs_t;

  obs_t sb[$];
  obs_t m_prev;
  logic m_sq;
  int   nvec = 0;
  int   nmiss = 0;

  function automatic in_t alu_op(logic [31:0] pc, logic [31:0] res, logic [4:0] d);
    in_t x = '0;
    x.v = 1'b1; x.pc = pc; x.alu = res; x.rd = d; x.rw = 1'b1;
    x.rs2 = 32'hDEAD_0000 | {27'd0, d};
    return x;
  endfunction

  function automatic in_t br_op(logic [31:0] pc, logic [31:0] imm, logic t);
    in_t x = '0;
    x.v = 1'b1; x.pc = pc; x.imm = imm; x.br = 1'b1; x.bb = t;
    x.alu = 32'h0000_0001; x.rw = 1'b1;  // decoder junk must not leak through
    return x;
  endfunction

  function automatic in_t jal_op(logic [31:0] pc, logic [31:0] imm);
    in_t x = '0;
    x.v = 1'b1; x.pc = pc; x.imm = imm; x.jal = 1'b1; x.rd = 5'd1; x.rw = 1'b1;
    x.alu = 32'h5555_5555;
    return x;
  endfunction

  function automatic in_t jalr_op(logic [31:0] pc, logic [31:0] a);
    in_t x = '0;
    x.v = 1'b1; x.pc = pc; x.alu = a; x.jalr = 1'b1; x.rd = 5'd1; x.rw = 1'b1;
    x.imm = 32'h0000_0700;
    return x;
  endfunction

  function automatic in_t mem_op(logic [31:0] pc, logic [31:0] addr, logic st,
                                 logic [31:0] data, logic [2:0] s);
    in_t x = '0;
    x.v = 1'b1; x.pc = pc; x.alu = addr; x.rs2 = data; x.sz = s;
    x.mw = st; x.mr = ~st; x.rw = ~st; x.rd = 5'd9;
    return x;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.v = mem_valid; o.pc = mem_pc; o.alu = mem_alu; o.rs2 = mem_rs2; o.rd = mem_rd;
    o.rw = mem_rw; o.mr = mem_mr; o.mw = mem_mw; o.sz = mem_sz;
    o.redir = redirect; o.rpc = redirect_pc; o.mis = mis_trap;
    return o;
  endfunction

  // Drive one cycle of EX inputs, predict the registered outputs, clock.
  task automatic step(input in_t x);
    obs_t e;
    logic acc, tk, ms, jmp;
    logic [31:0] tgt;
    rst = x.rst; stall = x.stall; flush = x.flush; ex_valid = x.v;
    ex_pc = x.pc; ex_imm = x.imm; alu = x.alu; bb = x.bb; is_br = x.br;
    is_jal = x.jal; is_jalr = x.jalr; rs2 = x.rs2; rd = x.rd;
    rw = x.rw; mr = x.mr; mw = x.mw; sz = x.sz;
    e = '0;
    if (x.rst) begin
      e.pc = RST_PC;
      m_sq = 1'b0;
    end else if (x.stall) begin
      e = m_prev;
      e.redir = 1'b0;
      e.mis = 1'b0;
    end else begin
      acc = x.v & ~m_sq & ~x.flush;
      jmp = x.jal | x.jalr;
      tgt = x.jalr ? (x.alu & 32'hFFFF_FFFE) : (x.pc + x.imm);
      tk  = acc & ((x.br & x.bb) | jmp);
      ms  = tk & tgt[1];
      e.v = acc; e.pc = x.pc; e.rs2 = x.rs2; e.rd = x.rd; e.sz = x.sz;
      e.alu = jmp ? (x.pc + 32'd4) : x.alu;
      e.rw  = x.rw & acc & ~x.br & ~ms;
      e.mr  = x.mr & acc & ~ms;
      e.mw  = x.mw & acc & ~ms;
      e.redir = tk & ~ms;
      e.rpc = tgt;
      e.mis = ms;
      m_sq = e.redir;
    end
    m_prev = e;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_t  t[2];
    obs_t e, g;
    t[0] = '0; t[0].rst = 1'b1;
    t[1] = jal_op(32'h10, 32'h40); t[1].rst = 1'b1;  // rst beats a taken jump
    foreach (t[i]) begin
      step(t[i]);
      e = sb.pop_front(); g = sample(); nvec++;
      if (g !== e) begin
        nmiss++; $display("FAIL reset[%0d]: got %h want %h", i, g, e);
      end
    end
    nvec++;
    if (mem_pc !== RST_PC) begin
      nmiss++; $display("FAIL reset_pc: got %h want %h", mem_pc, RST_PC);
    end
  endtask

  task automatic test_alu();
    in_t  t[3];
    obs_t e, g;
    t[0] = alu_op(32'h40, 32'h0000_0010, 5'd5);
    t[1] = mem_op(32'h44, 32'h0000_1000, 1'b0, 32'h0, MEM_HU);
    t[2] = mem_op(32'h48, 32'h0000_1004, 1'b1, 32'hCAFE_F00D, MEM_W);
    foreach (t[i]) begin
      step(t[i]);
      e = sb.pop_front(); g = sample(); nvec++;
      if (g !== e) begin
        nmiss++; $display("FAIL alu_mem[%0d]: got %h want %h", i, g, e);
      end
      if (i == 0) begin
        nvec++;
        if ({mem_alu, mem_rd, mem_rw, redirect} !== {32'h10, 5'd5, 1'b1, 1'b0}) begin
          nmiss++;
          $display("FAIL add_fields: got %h/%0d/%b/%b want 10/5/1/0",
                   mem_alu, mem_rd, mem_rw, redirect);
        end
      end
    end
  endtask

  task automatic test_branch();
    in_t  t[4];
    obs_t e, g;
    t[0] = br_op(32'h100, 32'h20, 1'b1);
    t[1] = alu_op(32'h104, 32'h77, 5'd3);   // wrong path
    t[2] = alu_op(32'h120, 32'h88, 5'd4);
    t[3] = br_op(32'h124, 32'h40, 1'b0);   // not taken
    foreach (t[i]) begin
      step(t[i]);
      e = sb.pop_front(); g = sample(); nvec++;
      if (g !== e) begin
        nmiss++; $display("FAIL branch[%0d]: got %h want %h", i, g, e);
      end
      if (i == 0) begin
        nvec++;
        if ({redirect, redirect_pc} !== {1'b1, 32'h120}) begin
          nmiss++; $display("FAIL beq_redirect: got %b %h want 1 120", redirect, redirect_pc);
        end
      end
      if (i == 1) begin
        nvec++;
        if (mem_valid !== 1'b0) begin
          nmiss++; $display("FAIL squash: got valid %b want 0", mem_valid);
        end
      end
    end
  endtask

  task automatic test_jalr();
    in_t  t[5];
    obs_t e, g;
    t[0] = jalr_op(32'h200, 32'h0000_2003);
    t[1] = alu_op(32'h204, 32'h1, 5'd7);    // trap does not squash
    t[2] = jalr_op(32'h200, 32'h0000_2001);
    t[3] = alu_op(32'h204, 32'h2, 5'd8);    // wrong path
    t[4] = br_op(32'h300, 32'h2, 1'b1);     // misaligned branch target
    foreach (t[i]) begin
      step(t[i]);
      e = sb.pop_front(); g = sample(); nvec++;
      if (g !== e) begin
        nmiss++; $display("FAIL jalr[%0d]: got %h want %h", i, g, e);
      end
      if (i == 0) begin
        nvec++;
        if ({mis_trap, redirect, mem_rw, mem_valid, redirect_pc} !== {4'b1001, 32'h2002}) begin
          nmiss++;
          $display("FAIL jalr_misalign: got %b%b%b%b %h want 1001 2002",
                   mis_trap, redirect, mem_rw, mem_valid, redirect_pc);
        end
      end
      if (i == 2) begin
        nvec++;
        if ({redirect, redirect_pc, mem_alu} !== {1'b1, 32'h2000, 32'h204}) begin
          nmiss++;
          $display("FAIL jalr_ok: got %b %h %h want 1 2000 204", redirect, redirect_pc, mem_alu);
        end
      end
    end
  endtask

  task automatic test_jal_wrap();
    in_t  t[2];
    obs_t e, g;
    t[0] = jal_op(32'hFFFF_FFFC, 32'h8);
    t[1] = alu_op(32'h0, 32'h3, 5'd2);
    foreach (t[i]) begin
      step(t[i]);
      e = sb.pop_front(); g = sample(); nvec++;
      if (g !== e) begin
        nmiss++; $display("FAIL jal_wrap[%0d]: got %h want %h", i, g, e);
      end
      if (i == 0) begin
        nvec++;
        if ({redirect_pc, mem_alu} !== {32'h4, 32'h0}) begin
          nmiss++; $display("FAIL jal_wrap_val: got %h %h want 4 0", redirect_pc, mem_alu);
        end
      end
    end
  endtask

  task automatic test_stall();
    in_t  t[11];
    obs_t e, g, held;
    int   nred = 0;
    t[0] = mem_op(32'h400, 32'h2000, 1'b1, 32'h1234_5678, MEM_H);
    for (int i = 1; i <= 3; i++) begin
      t[i] = alu_op(32'h404, 32'h9, 5'd10); t[i].stall = 1'b1;
    end
    t[4] = alu_op(32'h404, 32'h9, 5'd10);
    t[5] = br_op(32'h408, 32'h10, 1'b1);
    t[6] = alu_op(32'h40C, 32'hA, 5'd11); t[6].stall = 1'b1;
    t[7] = t[6];
    t[8] = alu_op(32'h40C, 32'hA, 5'd11);  // wrong path once stall drops
    t[9] = alu_op(32'h418, 32'hB, 5'd12);
    t[10] = t[9];
    held = '0;
    foreach (t[i]) begin
      step(t[i]);
      e = sb.pop_front(); g = sample(); nvec++;
      if (g !== e) begin
        nmiss++; $display("FAIL stall[%0d]: got %h want %h", i, g, e);
      end
      if (i == 0) held = g;
      if (i >= 1 && i <= 3) begin
        nvec++;
        if (g !== held) begin
          nmiss++; $display("FAIL stall_hold[%0d]: got %h want %h", i, g, held);
        end
      end
      if (i >= 5 && i <= 8) nred += int'(redirect);
    end
    nvec++;
    if (nred != 1) begin
      nmiss++; $display("FAIL redirect_pulse: got %0d cycles want 1", nred);
    end
  endtask

  task automatic test_flush();
    in_t  t[6];
    obs_t e, g;
    t[0] = br_op(32'h500, 32'h40, 1'b1); t[0].flush = 1'b1;
    t[1] = alu_op(32'h504, 32'h1, 5'd1); t[1].flush = 1'b1; t[1].stall = 1'b1;
    t[2] = alu_op(32'h504, 32'h1, 5'd1);
    t[3] = jal_op(32'h508, 32'h100);
    t[4] = alu_op(32'h50C, 32'h2, 5'd2); t[4].rst = 1'b1;  // reset in redirect cycle
    t[5] = alu_op(32'h600, 32'h3, 5'd3);                   // must not be squashed
    foreach (t[i]) begin
      step(t[i]);
      e = sb.pop_front(); g = sample(); nvec++;
      if (g !== e) begin
        nmiss++; $display("FAIL flush_rst[%0d]: got %h want %h", i, g, e);
      end
    end
    nvec++;
    if ({mem_valid, mem_pc} !== {1'b1, 32'h600}) begin
      nmiss++; $display("FAIL post_rst: got %b %h want 1 600", mem_valid, mem_pc);
    end
  endtask

  task automatic test_back_to_back();
    in_t  x;
    obs_t e, g;
    logic [31:0] pc;
    for (int i = 0; i < 200; i++) begin
      pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      case ($urandom_range(0, 5))
        0: x = br_op(pc, {$urandom_range(0, 255), 1'b0}, 1'($urandom_range(0, 1)));
        1: x = jal_op(pc, {$urandom_range(0, 255), 1'b0});
        2: x = jalr_op(pc, $urandom());
        3: x = mem_op(pc, $urandom(), 1'($urandom_range(0, 1)), $urandom(),
                      3'($urandom_range(0, 5)));
        default: x = alu_op(pc, $urandom(), 5'($urandom_range(0, 31)));
      endcase
      x.v     = ($urandom_range(0, 7) != 0);
      x.stall = ($urandom_range(0, 5) == 0);
      x.flush = ($urandom_range(0, 7) == 0);
      x.rst   = ($urandom_range(0, 39) == 0);
      step(x);
      e = sb.pop_front(); g = sample(); nvec++;
      if (g !== e) begin
        nmiss++; $display("FAIL random[%0d]: got %h want %h", i, g, e);
      end
    end
  endtask

  initial begin
    m_sq = 1'b0;
    m_prev = '0;
    {rst, ex_valid, bb, is_br, is_jal, is_jalr, rw, mr, mw, stall, flush} = '0;
    {ex_pc, ex_imm, alu, rs2} = '0;
    rd = '0; sz = '0;
    #1;
    test_reset();
    test_alu();
    test_branch();
    test_jalr();
    test_jal_wrap();
    test_stall();
    test_flush();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule
